// File: rtl/modport_mem_pkg.sv
// Shared defaults and word/address types for the small synchronous memory.
package mem_pkg;

  localparam int MEM_ADDR_WIDTH = 2;
  localparam int MEM_DATA_WIDTH = 8;
  localparam logic [MEM_DATA_WIDTH-1:0] MEM_RESET_VALUE = '0;

  typedef logic [MEM_DATA_WIDTH-1:0] word_t;
  typedef logic [MEM_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/modport_mem_if.sv
// Signal bundle between the memory and whoever drives it.
interface mem_intf
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output addr,
    output wr_en,
    output rd_en,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wr_en,
    input  rd_en,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/modport_mem_array.sv
// Storage array: one shared address, registered read port, read-before-write on collision.
module mem_array
  import mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = MEM_RESET_VALUE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Both the read and the write sample mem before this edge's update,
  // which gives old data on a same-address read/write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VALUE;
      end
      rdata <= RESET_VALUE;
    end else begin
      if (re) begin
        rdata <= mem[addr];
      end
      if (we) begin
        mem[addr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/modport_mem.sv
// Top of the 4x8 synchronous memory: qualifies the enables and maps the bundle onto the array.
module modport_mem
  import mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = MEM_RESET_VALUE
) (
  input  logic   clk,
  input  logic   reset,
  mem_intf.slave bus
);

  logic wr_q;
  logic rd_q;

  // Only a clean 1 enables an update; X or Z on a strobe behaves as idle.
  assign wr_q = (bus.wr_en === 1'b1);
  assign rd_q = (bus.rd_en === 1'b1);

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_array (
    .clk  (clk),
    .rst_n(reset),
    .addr (bus.addr),
    .we   (wr_q),
    .re   (rd_q),
    .wdata(bus.wdata),
    .rdata(bus.rdata)
  );

  a_wr_en_known: assert property (@(posedge clk) disable iff (!reset) !$isunknown(bus.wr_en))
    else $error("wr_en is X/Z outside reset");

  a_rd_en_known: assert property (@(posedge clk) disable iff (!reset) !$isunknown(bus.rd_en))
    else $error("rd_en is X/Z outside reset");

endmodule

// File: tb/tb_modport_mem.sv
// Directed bench for modport_mem: reset, write/read, collision, hold, back-to-back, mid-traffic reset.
module tb_modport_mem;
  import mem_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_intf #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

  modport_mem dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_write(input addr_t a, input word_t d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b0;
    tick();
    idle();
  endtask

  task automatic do_read(input addr_t a);
    bus.addr  = a;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected %h", bus.rdata, 8'h00);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_read(addr_t'(i));
      n_checks++;
      if (bus.rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_read_a%0d: got %h expected %h", i, bus.rdata, 8'h00);
      end
    end
  endtask

  task automatic test_write_read();
    word_t exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) do_write(addr_t'(i), exp[i]);
    for (int i = 0; i < 4; i++) begin
      do_read(addr_t'(i));
      n_checks++;
      if (bus.rdata !== exp[i]) begin
        n_fail++;
        $display("FAIL wr_rd_a%0d: got %h expected %h", i, bus.rdata, exp[i]);
      end
    end
  endtask

  task automatic test_collision();
    bus.addr  = 2'd2;
    bus.wdata = 8'hA5;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    idle();
    n_checks++;
    if (bus.rdata !== 8'h33) begin
      n_fail++;
      $display("FAIL collide_old: got %h expected %h", bus.rdata, 8'h33);
    end
    do_read(2'd2);
    n_checks++;
    if (bus.rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL collide_new: got %h expected %h", bus.rdata, 8'hA5);
    end
  endtask

  task automatic test_hold();
    do_read(2'd1);
    n_checks++;
    if (bus.rdata !== 8'h22) begin
      n_fail++;
      $display("FAIL hold_first: got %h expected %h", bus.rdata, 8'h22);
    end
    for (int i = 0; i < 3; i++) begin
      bus.addr  = 2'd1;
      bus.wdata = 8'hFF;
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b0;
      tick();
      n_checks++;
      if (bus.rdata !== 8'h22) begin
        n_fail++;
        $display("FAIL hold_cyc%0d: got %h expected %h", i, bus.rdata, 8'h22);
      end
    end
    idle();
    do_read(2'd1);
    n_checks++;
    if (bus.rdata !== 8'hFF) begin
      n_fail++;
      $display("FAIL hold_after: got %h expected %h", bus.rdata, 8'hFF);
    end
  endtask

  task automatic test_back_to_back();
    addr_t a_seq [4];
    word_t e_seq [4];
    a_seq = '{2'd3, 2'd0, 2'd2, 2'd1};
    e_seq = '{8'h44, 8'h11, 8'h33, 8'h22};
    do_write(2'd1, 8'h22);
    do_write(2'd2, 8'h33);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.addr = a_seq[i];
      tick();
      n_checks++;
      if (bus.rdata !== e_seq[i]) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h expected %h", i, bus.rdata, e_seq[i]);
      end
    end
    idle();
  endtask

  task automatic test_diff_addr();
    bus.addr  = 2'd0;
    bus.wdata = 8'h5A;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b0;
    // Single port: write addr 0 this cycle, then read it back while a read of addr 3 precedes.
    tick();
    idle();
    do_read(2'd3);
    n_checks++;
    if (bus.rdata !== 8'h44) begin
      n_fail++;
      $display("FAIL diff_rd3: got %h expected %h", bus.rdata, 8'h44);
    end
    do_read(2'd0);
    n_checks++;
    if (bus.rdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL diff_rd0: got %h expected %h", bus.rdata, 8'h5A);
    end
  endtask

  task automatic test_mid_reset();
    do_read(2'd3);
    n_checks++;
    if (bus.rdata !== 8'h44) begin
      n_fail++;
      $display("FAIL midrst_pre: got %h expected %h", bus.rdata, 8'h44);
    end
    bus.wr_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.addr  = addr_t'(i);
      bus.wdata = word_t'(8'hC0 + i);
      tick();
    end
    bus.addr  = 2'd2;
    bus.wdata = 8'hC2;
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_async: got %h expected %h", bus.rdata, 8'h00);
    end
    tick();
    tick();
    idle();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_read(addr_t'(i));
      n_checks++;
      if (bus.rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL midrst_a%0d: got %h expected %h", i, bus.rdata, 8'h00);
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    test_reset();
    test_write_read();
    test_collision();
    test_hold();
    test_back_to_back();
    test_diff_addr();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
